// File: rtl/xpb_pkg.sv
// Shared definitions for the XPB sequencing logic: default widths, FSM
// state encoding and a small width helper.
package xpb_pkg;

    localparam int XPB_DIGIT_W = 5;
    localparam int XPB_DATA_W  = 1024;

    typedef logic [1:0] xpb_state_t;

    localparam xpb_state_t ST_IDLE  = 2'd0;
    localparam xpb_state_t ST_ISSUE = 2'd1;
    localparam xpb_state_t ST_DRAIN = 2'd2;
    localparam xpb_state_t ST_DONE  = 2'd3;

    // Index/select width; never narrower than one bit so a single-digit
    // configuration still has a legal port.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/xpb_seq_ctrl_acc.sv
// Registered accumulator for XPB table entries: clears on operation
// acceptance and adds one zero-extended entry per enabled cycle.
module xpb_acc_add #(
    parameter int DATA_W = 1024,
    parameter int ACC_W  = 1027
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [DATA_W-1:0] addend,
    output logic [ACC_W-1:0]  acc
);

    logic [ACC_W-1:0] addend_ext;

    // The extra high bits give headroom so the sum of all entries is exact.
    assign addend_ext = {{(ACC_W - DATA_W){1'b0}}, addend};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + addend_ext;
        end
    end

endmodule

// File: rtl/xpb_seq_ctrl.sv
// Sequencer that walks the latched operand digits through the external XPB
// table bank and accumulates the selected entries into an exact sum.
module xpb_seq_ctrl
    import xpb_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int DIGIT_W    = XPB_DIGIT_W,
    parameter int DATA_W     = XPB_DATA_W,
    localparam int SEL_W     = sel_width(NUM_DIGITS),
    localparam int ACC_W     = DATA_W + SEL_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [NUM_DIGITS*DIGIT_W-1:0] digits_in,
    output logic                          ready,
    output logic                          busy,
    output logic [DIGIT_W-1:0]            lut_addr,
    output logic [SEL_W-1:0]              lut_sel,
    input  logic [DATA_W-1:0]             lut_data,
    output logic [ACC_W-1:0]              sum_out,
    output logic                          done,
    output logic [1:0]                    fsm_state
);

    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_DIGITS - 1);

    // Handshake: an operation is accepted on a rising edge where start=1 and
    // ready=1; start in any other state is ignored, and the result is only
    // meaningful in the single cycle where done=1.

    xpb_state_t                    state;
    logic [SEL_W-1:0]              idx;
    logic [NUM_DIGITS*DIGIT_W-1:0] digit_reg;
    logic                          accept;
    logic                          acc_en;

    assign accept = (state == ST_IDLE) && start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            idx       <= '0;
            digit_reg <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        digit_reg <= digits_in;
                        idx       <= '0;
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (idx == LAST_IDX) begin
                        idx   <= '0;
                        state <= ST_DRAIN;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_DRAIN: state <= ST_DONE;
                ST_DONE:  state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    // Table data lags the address by one cycle, so the first issue cycle has
    // nothing to add yet and the drain cycle collects the last entry.
    assign acc_en = ((state == ST_ISSUE) && (idx != '0)) || (state == ST_DRAIN);

    always_comb begin
        lut_addr = '0;
        lut_sel  = '0;
        if (state == ST_ISSUE) begin
            lut_addr = digit_reg[int'(idx)*DIGIT_W +: DIGIT_W];
            lut_sel  = idx;
        end
    end

    xpb_acc_add #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_acc (
        .clk    (clk),
        .rst    (rst),
        .clr    (accept),
        .en     (acc_en),
        .addend (lut_data),
        .acc    (sum_out)
    );

    assign ready     = (state == ST_IDLE);
    assign busy      = (state == ST_ISSUE) || (state == ST_DRAIN);
    assign done      = (state == ST_DONE);
    assign fsm_state = state;

endmodule
